rvmyth_out_uart: RTL and testbench

Output capture and serial streaming stage sitting directly downstream of the `rvmyth` core. It consumes the core's 10-bit `OUT` bus and pushes every value change into a small FIFO. It then transmits each queued value as a 12-bit asynchronous serial frame on `tx`. This lets simulation benches and FPGA bring-up observe the core's output stream without a parallel probe.

---
 rtl/rvmyth_out_uart.sv | 133 +++++++++++++
 tb/tb_rvmyth_out_uart.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rvmyth_out_uart.sv
// Captures every change on the rvmyth OUT bus into a small FIFO and streams
// each queued value out as a 12-bit serial frame (start, 10 data LSB first, stop).
module rvmyth_out_uart #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_AW      = 3
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic [9:0]         out_in,
    output logic               tx,
    output logic               busy,
    output logic               overflow,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0]    TMAX    = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]    TONE    = TW'(1);
    localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state;
    logic [TW-1:0]      timer;
    logic [3:0]         bit_idx;
    logic [9:0]         shift;
    logic [9:0]         prev_q;
    logic [9:0]         mem [DEPTH];
    logic [FIFO_AW:0]   wr_ptr;
    logic [FIFO_AW:0]   rd_ptr;
    logic               push_req;
    logic               push_ok;
    logic               pop;
    logic               full;
    logic               empty;

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]) &&
                        (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]);
    assign pop        = (state == IDLE) && !empty;
    assign push_req   = (out_in != prev_q);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still legal then.
    assign push_ok    = push_req && (!full || pop);
    assign fifo_count = wr_ptr - rd_ptr;

    always_ff @(posedge CLK) begin
        if (push_ok)
            mem[wr_ptr[FIFO_AW-1:0]] <= out_in;
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            prev_q   <= 10'h000;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_req)
                prev_q <= out_in;
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            else if (push_req)
                overflow <= 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Transmitter: tx and busy are registered next to the state so the line never glitches.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= 4'd0;
            shift   <= 10'h000;
            tx      <= 1'b1;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift <= mem[rd_ptr[FIFO_AW-1:0]];
                        timer <= TMAX;
                        state <= START;
                        tx    <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                START: begin
                    if (timer == '0) begin
                        timer   <= TMAX;
                        bit_idx <= 4'd0;
                        state   <= DATA;
                        tx      <= shift[0];
                    end else begin
                        timer <= timer - TONE;
                    end
                end
                DATA: begin
                    if (timer == '0) begin
                        timer <= TMAX;
                        if (bit_idx == 4'd9) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            shift   <= shift >> 1;
                            bit_idx <= bit_idx + 4'd1;
                            tx      <= shift[1];
                        end
                    end else begin
                        timer <= timer - TONE;
                    end
                end
                STOP: begin
                    if (timer == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        timer <= timer - TONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rvmyth_out_uart.sv
// Bench for rvmyth_out_uart: table of single-value frames plus hand-written
// sequences for burst/overflow, full-FIFO push/pop, change filtering and mid-frame reset.
module tb_rvmyth_out_uart;

    localparam int CPB = 4;
    localparam int AW  = 2;

    logic          CLK;
    logic          reset;
    logic [9:0]    out_in;
    logic          tx;
    logic          busy;
    logic          overflow;
    logic [AW:0]   fifo_count;

    int checks;
    int errors;
    logic [11:0] frames [$];

    typedef struct {
        logic [9:0]  din;
        logic [11:0] exp_frame;
        int          exp_count;
    } vec_t;

    vec_t vecs [6];

    rvmyth_out_uart #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .out_in     (out_in),
        .tx         (tx),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic [9:0] v);
        out_in = v;
        tick();
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic waitFrames(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (frames.size() >= n && !busy) break;
            tick();
        end
        repeat (60) tick();
    endtask

    task automatic checkFrame(input string name, input logic [9:0] val);
        if (frames.size() == 0) begin
            checkOutput({name, "_present"}, 0, 1);
        end else begin
            checkOutput(name, int'(frames.pop_front()), int'({1'b1, val, 1'b0}));
        end
    endtask

    // Mid-bit receiver: pushes every complete frame that was not cut by reset.
    initial begin
        logic [11:0] f;
        bit aborted;
        forever begin
            tick();
            if (reset && tx == 1'b0) begin
                aborted = 1'b0;
                for (int i = 0; i < 12; i++) begin
                    repeat ((i == 0) ? 2 : CPB) begin
                        tick();
                        if (!reset) aborted = 1'b1;
                    end
                    f[i] = tx;
                end
                if (!aborted) frames.push_back(f);
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int busy_len;
        bit saw;

        checks = 0;
        errors = 0;
        reset  = 1'b0;
        out_in = 10'h000;

        vecs[0] = '{din: 10'h2A5, exp_frame: 12'hD4A, exp_count: 1};
        vecs[1] = '{din: 10'h001, exp_frame: 12'h802, exp_count: 1};
        vecs[2] = '{din: 10'h3FF, exp_frame: 12'hFFE, exp_count: 1};
        vecs[3] = '{din: 10'h000, exp_frame: 12'h800, exp_count: 1};
        vecs[4] = '{din: 10'h155, exp_frame: 12'hAAA, exp_count: 1};
        vecs[5] = '{din: 10'h200, exp_frame: 12'hC00, exp_count: 1};

        $display("[TB] reset and idle line");
        repeat (5) tick();
        checkOutput("tx_in_reset", int'(tx), 1);
        reset = 1'b1;
        tick();
        checkOutput("reset_tx", int'(tx), 1);
        checkOutput("reset_busy", int'(busy), 0);
        checkOutput("reset_overflow", int'(overflow), 0);
        checkOutput("reset_count", int'(fifo_count), 0);
        saw = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx == 1'b0 || busy) saw = 1'b1;
        end
        checkOutput("idle_no_frame", int'(saw), 0);
        checkOutput("idle_no_frames_decoded", frames.size(), 0);

        $display("[TB] single-value frames");
        for (int v = 0; v < 6; v++) begin
            frames.delete();
            applyStimulus(vecs[v].din);
            checkOutput("count_after_push", int'(fifo_count), vecs[v].exp_count);
            lat = 1;
            for (int i = 0; i < 10; i++) begin
                tick();
                lat++;
                if (tx == 1'b0) break;
            end
            checkOutput("start_latency", lat, 2);
            checkOutput("busy_at_start", int'(busy), 1);
            busy_len = 1;
            for (int i = 0; i < 80; i++) begin
                tick();
                if (busy) busy_len++;
                else break;
            end
            checkOutput("busy_length", busy_len, 12 * CPB);
            checkOutput("count_after_frame", int'(fifo_count), 0);
            tick();
            if (frames.size() == 0)
                checkOutput("frame_present", 0, 1);
            else
                checkOutput("frame_bits", int'(frames.pop_front()), int'(vecs[v].exp_frame));
        end

        $display("[TB] burst and overflow");
        frames.delete();
        for (int i = 1; i <= 6; i++) applyStimulus(10'(i));
        checkOutput("burst_count", int'(fifo_count), 4);
        checkOutput("burst_overflow", int'(overflow), 1);
        waitFrames(5, 400);
        checkOutput("burst_frames", frames.size(), 5);
        for (int i = 1; i <= 5; i++) checkFrame("burst_frame", 10'(i));
        checkOutput("overflow_sticky", int'(overflow), 1);
        checkOutput("burst_drained", int'(fifo_count), 0);

        $display("[TB] full fifo with simultaneous push and pop");
        reset  = 1'b0;
        out_in = 10'h000;
        repeat (3) tick();
        reset = 1'b1;
        tick();
        checkOutput("overflow_cleared", int'(overflow), 0);
        frames.delete();
        applyStimulus(10'h011);
        applyStimulus(10'h022);
        applyStimulus(10'h033);
        applyStimulus(10'h044);
        applyStimulus(10'h055);
        checkOutput("fill_count", int'(fifo_count), 4);
        checkOutput("fill_no_overflow", int'(overflow), 0);
        for (int i = 0; i < 100; i++) begin
            if (!busy) break;
            tick();
        end
        checkOutput("full_at_idle", int'(fifo_count), 4);
        applyStimulus(10'h066);
        checkOutput("pushpop_count", int'(fifo_count), 4);
        checkOutput("pushpop_overflow", int'(overflow), 0);
        checkOutput("pushpop_busy", int'(busy), 1);
        waitFrames(6, 500);
        checkOutput("full_frames", frames.size(), 6);
        checkFrame("full_frame_a", 10'h011);
        checkFrame("full_frame_b", 10'h022);
        checkFrame("full_frame_c", 10'h033);
        checkFrame("full_frame_d", 10'h044);
        checkFrame("full_frame_e", 10'h055);
        checkFrame("full_frame_f", 10'h066);

        $display("[TB] no-change filtering");
        frames.delete();
        applyStimulus(10'h005);
        applyStimulus(10'h005);
        applyStimulus(10'h005);
        applyStimulus(10'h007);
        waitFrames(2, 300);
        checkOutput("filter_frames", frames.size(), 2);
        checkFrame("filter_frame_5", 10'h005);
        checkFrame("filter_frame_7", 10'h007);

        $display("[TB] reset mid-frame");
        frames.delete();
        applyStimulus(10'h3EF);
        applyStimulus(10'h0F0);
        applyStimulus(10'h10F);
        repeat (21) tick();
        checkOutput("midframe_busy", int'(busy), 1);
        checkOutput("midframe_data_bit4", int'(tx), 0);
        checkOutput("midframe_queued", int'(fifo_count), 2);
        #2;
        reset  = 1'b0;
        out_in = 10'h000;
        #1;
        checkOutput("abort_tx", int'(tx), 1);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_count", int'(fifo_count), 0);
        repeat (3) tick();
        reset = 1'b1;
        frames.delete();
        saw = 1'b0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (tx == 1'b0 || busy) saw = 1'b1;
        end
        checkOutput("post_abort_silent", int'(saw), 0);
        checkOutput("post_abort_frames", frames.size(), 0);
        checkOutput("post_abort_overflow", int'(overflow), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
